// File: rtl/instruction_fetch_pkg.sv
// Shared encodings and constants for the LEGv8 fetch stage and its helpers.
package instruction_fetch_pkg;
    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_FAULT = 2'd3
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    // Opcode field handed to the decoder.
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 21;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode/retire side.
interface instruction_fetch_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   retire;
    logic                   take_branch;
    logic [PC_WIDTH-1:0]    branch_offset;
    logic                   fault;
    logic [31:0]            retired_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, fault, retired_count,
        input  imem_ready, imem_rvalid, imem_rdata, retire, take_branch, branch_offset
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, fault, retired_count,
        output imem_ready, imem_rvalid, imem_rdata, retire, take_branch, branch_offset
    );
endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC: sequential +4 or branch target, with alignment flag.
module next_pc_calc
    import instruction_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                take_branch_i,
    input  logic [PC_WIDTH-1:0] branch_offset_i,
    output logic [PC_WIDTH-1:0] next_pc_o,
    output logic                misaligned_o
);
    // Two's-complement add gives backward branches and silent wrap for free.
    assign next_pc_o    = pc_i + (take_branch_i ? branch_offset_i : PC_WIDTH'(INSTR_BYTES));
    assign misaligned_o = |next_pc_o[1:0];
endmodule

// File: rtl/instruction_fetch.sv
// Non-pipelined LEGv8 fetch: owns the PC, fetches one word, holds it until retire.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    fetch_state_e           state_q, state_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   instr_valid_q;
    logic [31:0]            retired_count_q;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   misaligned;
    logic                   req_out, fault_out;
    logic                   retire_fire, resp_fire;

    next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
        .pc_i           (pc_q),
        .take_branch_i  (bus.take_branch),
        .branch_offset_i(bus.branch_offset),
        .next_pc_o      (next_pc),
        .misaligned_o   (misaligned)
    );

    assign retire_fire = (state_q == FETCH_HOLD) && bus.retire;
    assign resp_fire   = (state_q == FETCH_WAIT) && bus.imem_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // req is registered so it stays low in the reset cycle and rises one edge later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_REQ:   if (req_q && bus.imem_ready) state_d = FETCH_WAIT;
            FETCH_WAIT:  if (bus.imem_rvalid)         state_d = FETCH_HOLD;
            FETCH_HOLD:  if (bus.retire)              state_d = misaligned ? FETCH_FAULT : FETCH_REQ;
            FETCH_FAULT: state_d = FETCH_FAULT;
            default:     state_d = FETCH_FAULT;
        endcase
        req_d = (state_d == FETCH_REQ);
    end

    always_comb begin
        req_out   = req_q && (state_q == FETCH_REQ);
        fault_out = (state_q == FETCH_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            instr_q         <= '0;
            instr_valid_q   <= 1'b0;
            retired_count_q <= '0;
        end else begin
            if (resp_fire) begin
                instr_q       <= bus.imem_rdata;
                instr_valid_q <= 1'b1;
            end
            if (retire_fire) begin
                instr_valid_q   <= 1'b0;
                retired_count_q <= retired_count_q + 32'd1;
                // A misaligned target freezes the PC at the offending branch.
                if (!misaligned) pc_q <= next_pc;
            end
        end
    end

    assign bus.imem_req      = req_out;
    assign bus.imem_addr     = pc_q;
    assign bus.pc            = pc_q;
    assign bus.instr         = instr_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.fault         = fault_out;
    assign bus.retired_count = retired_count_q;
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the non-pipelined LEGv8 datapath; sits directly upstream of the decode/control stage.
- Owns the PC and issues one request per instruction to instruction memory over a req/ready, rvalid handshake.
- Holds the fetched word stable for decode until the datapath signals retirement, then advances PC by +4 or to the branch target supplied by the branch logic.

Parameters:
- PC_WIDTH, 64, PC and address width in bits.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  PC_WIDTH  byte address of request, equals pc.
- imem_ready  in  1  memory accepts request this cycle when high with imem_req.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  INSTR_WIDTH  returned instruction word.
- instr_valid  out  1  instr/pc hold a fetched instruction for decode.
- instr  out  INSTR_WIDTH  current instruction; bits [31:21] feed the decoder opcode.
- pc  out  PC_WIDTH  address of current instruction.
- retire  in  1  one-cycle pulse: current instruction completed.
- take_branch  in  1  sampled with retire: redirect to branch target.
- branch_offset  in  PC_WIDTH  signed byte offset, already sign-extended and shifted left by 2.
- fault  out  1  sticky misaligned-target fault.
- retired_count  out  32  number of retired instructions.

Behaviour:
- Reset (async, any state): state=REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, retired_count=0. imem_req rises on the first edge after reset release. Instruction memory shares the same reset, so there are no in-flight responses after reset.
- States: REQ, WAIT, HOLD, FAULT.
- REQ: imem_req=1, imem_addr=pc. On imem_ready=1 go to WAIT next cycle and drop imem_req. Otherwise stay in REQ with the address stable.
- WAIT: imem_req=0. On imem_rvalid, register instr=imem_rdata, set instr_valid=1, go to HOLD. Minimum latency from request acceptance to instr_valid is 1 cycle if rvalid arrives in the same cycle the state enters WAIT.
- HOLD: instr and pc stay stable. On retire:
  - next_pc = pc+4 if take_branch=0, else pc+branch_offset.
  - retired_count increments.
  - instr_valid=0 next cycle.
  - If next_pc[1:0]!=0, go to FAULT with pc unchanged. Otherwise pc=next_pc and go to REQ.
- FAULT: fault=1, imem_req=0, instr_valid=0. Terminal until reset.
- Arithmetic: all PC sums are modulo 2^PC_WIDTH. 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0, with no flag. Branch offset is two's complement, so negative offsets go backwards.
- retired_count wraps 0xFFFFFFFF->0.
- Ignored inputs:
  - imem_rvalid outside WAIT is ignored.
  - retire outside HOLD is ignored: no count, no PC change.
  - take_branch without retire is ignored.
- Simultaneous events: reset dominates everything. A retire in the same cycle as entering HOLD is not possible, because instr_valid is registered and retire is only honoured in HOLD.
- imem_addr is always driven with pc, including while imem_req=0.

Decomposition:
- constants.vh:
  - state encodings FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_FAULT;
  - INSTR_BYTES=4;
  - OPCODE_MSB=31, OPCODE_LSB=21 (the field consumed by the decoder).
- Sub-module next_pc_calc: combinational; inputs pc, take_branch, branch_offset; outputs next_pc and misaligned. It is shared later with a pipelined fetch.

Test Plan:
- Reset release, imem_ready=1, rvalid 2 cycles later with data 0x8B020020 -> imem_addr=0, instr_valid=1, instr=0x8B020020, opcode bits=0x458; retire, take_branch=0 -> next imem_addr=4, retired_count=1.
- In HOLD at pc=0x40, retire, take_branch=1, branch_offset=0xFFFF_FFFF_FFFF_FFF0 -> pc=0x30, next request address 0x30.
- imem_ready held low for 5 cycles -> imem_req stays 1 and imem_addr stable; no instr_valid; proceeds once ready=1.
- Branch with branch_offset=0x6 from pc=0x10 -> fault=1, pc stays 0x10, imem_req never reasserts; retire and rvalid ignored; reset clears fault.
- pc=0xFFFF_FFFF_FFFF_FFFC, retire, no branch -> pc=0, no fault. Spurious rvalid in HOLD does not change instr. Retire in REQ does not change retired_count.
- Assert reset while in WAIT -> all outputs at reset values immediately (asynchronous), pc=RESET_PC, fetch restarts.
